// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared definitions for the PS/2 mouse cursor tracker: packet field
// positions, receiver state encoding and default screen/board geometry.
package mouse_pkg;

   localparam int LEFT    = 0;
   localparam int RIGHT   = 1;
   localparam int ALWAYS1 = 3;
   localparam int XSIGN   = 4;
   localparam int YSIGN   = 5;
   localparam int XOVF    = 6;
   localparam int YOVF    = 7;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int BOARD_X0_DEF = 80;
   localparam int BOARD_Y0_DEF = 0;
   localparam int SQUARE_DEF   = 60;
   localparam int TIMEOUT_DEF  = 20000;

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Cursor/event bundle from the mouse tracker to the display and game logic.
interface mouse_cursor_tracker_if;

   logic [10:0] cursor_x;
   logic [10:0] cursor_y;
   logic [5:0]  cursor_position;
   logic        on_board;
   logic        left_click;
   logic        packet_valid;
   logic        frame_error;

   modport master (
      output cursor_x, cursor_y, cursor_position, on_board,
             left_click, packet_valid, frame_error
   );

   modport slave (
      input  cursor_x, cursor_y, cursor_position, on_board,
             left_click, packet_valid, frame_error
   );

endinterface

// File: rtl/mouse_cursor_tracker_rx.sv
// PS/2 byte receiver: input synchronisers, clock glitch filter, 11-bit
// frame FSM with odd-parity/stop checking and an idle timeout.
module ps2_rx_byte
   import mouse_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic [3:0]    clk_hist;
   logic          clk_filt;
   logic          fall;
   logic          bit_in;
   logic          timeout;
   rx_state_t     state;
   rx_state_t     state_nxt;
   logic [2:0]    bit_cnt;
   logic          par_acc;
   logic [7:0]    shreg;
   logic [TW-1:0] idle_cnt;

   // The filtered clock only moves once four consecutive samples agree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_hist  <= 4'hF;
         clk_filt  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_hist  <= {clk_hist[2:0], clk_sync[1]};
         if (&clk_hist)
            clk_filt <= 1'b1;
         else if (~|clk_hist)
            clk_filt <= 1'b0;
      end
   end

   assign fall    = clk_filt && (clk_hist == 4'h0);
   assign bit_in  = data_sync[1];
   assign timeout = (state != IDLE) && !fall && (idle_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fall && !bit_in) state_nxt = DATA;
         DATA:    if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
         PARITY:  if (fall) state_nxt = (par_acc ^ bit_in) ? STOP : IDLE;
         STOP:    if (fall) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (timeout)
         state_nxt = IDLE;
   end

   always_comb begin
      byte_valid = 1'b0;
      err        = 1'b0;
      case (state)
         PARITY:  if (fall && !(par_acc ^ bit_in)) err = 1'b1;
         STOP:    if (fall) begin
                     byte_valid = bit_in;
                     err        = !bit_in;
                  end
         default: ;
      endcase
      if (timeout)
         err = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt  <= '0;
         par_acc  <= 1'b0;
         idle_cnt <= '0;
      end else begin
         idle_cnt <= (state == IDLE || fall) ? '0 : idle_cnt + 1'b1;
         if (state == IDLE) begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
         end else if (state == DATA && fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            par_acc <= par_acc ^ bit_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && fall)
         shreg <= {bit_in, shreg[7:1]};
   end

   assign rx_byte = shreg;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Assembles 3-byte PS/2 mouse packets, moves a saturating screen cursor
// and maps it onto the 8x8 board square beneath it.
module mouse_cursor_tracker
   import mouse_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int BOARD_X0 = BOARD_X0_DEF,
   parameter int BOARD_Y0 = BOARD_Y0_DEF,
   parameter int SQUARE   = SQUARE_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   mouse_cursor_tracker_if.master cur
);

   localparam logic signed [12:0] X_MAX = 13'(H_ACTIVE - 1);
   localparam logic signed [12:0] Y_MAX = 13'(V_ACTIVE - 1);

   function automatic logic [10:0] sat_axis(input logic [10:0] pos,
                                            input logic signed [12:0] delta,
                                            input logic signed [12:0] max_v);
      logic signed [12:0] sum;
      sum = $signed({2'b00, pos}) + delta;
      if (sum < 13'sd0)
         return '0;
      if (sum > max_v)
         return max_v[10:0];
      return sum[10:0];
   endfunction

   function automatic logic in_span(input logic [10:0] v, input int origin);
      return (int'(v) >= origin) && (int'(v) < origin + 8 * SQUARE);
   endfunction

   // Comparator ladder: count the square boundaries already passed.
   function automatic logic [2:0] ladder(input logic [10:0] v, input int origin);
      logic [2:0] idx;
      idx = '0;
      for (int k = 1; k < 8; k++)
         if (int'(v) >= origin + k * SQUARE)
            idx = idx + 3'd1;
      return idx;
   endfunction

   logic [7:0]         rx_byte;
   logic               byte_valid;
   logic               rx_err;
   logic [1:0]         byte_idx;
   logic               hdr_left, hdr_xsign, hdr_ysign, hdr_xovf, hdr_yovf;
   logic [7:0]         dx_mag;
   logic               apply;
   logic signed [8:0]  dx9, dy9;
   logic signed [12:0] dx, dy;
   logic               unused_hdr_bits;

   logic [10:0]        x_p1, y_p1;
   logic               vld_p1, click_p1, ferr_p1, prev_left;
   logic               on_board_p2;
   logic [5:0]         pos_p2;

   ps2_rx_byte #(.TIMEOUT(TIMEOUT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .err        (rx_err)
   );

   assign unused_hdr_bits = ^rx_byte[2:1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         byte_idx <= 2'd0;
      else if (rx_err)
         byte_idx <= 2'd0;
      else if (byte_valid)
         case (byte_idx)
            2'd0:    byte_idx <= rx_byte[ALWAYS1] ? 2'd1 : 2'd0;
            2'd1:    byte_idx <= 2'd2;
            default: byte_idx <= 2'd0;
         endcase
   end

   always_ff @(posedge clk) begin
      if (byte_valid && byte_idx == 2'd0) begin
         hdr_left  <= rx_byte[LEFT];
         hdr_xsign <= rx_byte[XSIGN];
         hdr_ysign <= rx_byte[YSIGN];
         hdr_xovf  <= rx_byte[XOVF];
         hdr_yovf  <= rx_byte[YOVF];
      end
      if (byte_valid && byte_idx == 2'd1)
         dx_mag <= rx_byte;
   end

   assign apply = byte_valid && (byte_idx == 2'd2);
   assign dx9   = hdr_xovf ? 9'sd0 : {hdr_xsign, dx_mag};
   assign dy9   = hdr_yovf ? 9'sd0 : {hdr_ysign, rx_byte};
   assign dx    = {{4{dx9[8]}}, dx9};
   assign dy    = {{4{dy9[8]}}, dy9};

   // Stage p1: cursor update and event pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_p1      <= 11'(H_ACTIVE / 2);
         y_p1      <= 11'(V_ACTIVE / 2);
         vld_p1    <= 1'b0;
         click_p1  <= 1'b0;
         ferr_p1   <= 1'b0;
         prev_left <= 1'b0;
      end else begin
         vld_p1   <= apply;
         click_p1 <= apply && hdr_left && !prev_left;
         ferr_p1  <= rx_err;
         if (apply) begin
            x_p1      <= sat_axis(x_p1, dx, X_MAX);
            y_p1      <= sat_axis(y_p1, -dy, Y_MAX);
            prev_left <= hdr_left;
         end
      end
   end

   // Stage p2: board square mapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         on_board_p2 <= 1'b0;
         pos_p2      <= 6'd0;
      end else begin
         on_board_p2 <= in_span(x_p1, BOARD_X0) && in_span(y_p1, BOARD_Y0);
         if (in_span(x_p1, BOARD_X0) && in_span(y_p1, BOARD_Y0))
            pos_p2 <= {ladder(y_p1, BOARD_Y0), ladder(x_p1, BOARD_X0)};
      end
   end

   assign cur.cursor_x        = x_p1;
   assign cur.cursor_y        = y_p1;
   assign cur.cursor_position = pos_p2;
   assign cur.on_board        = on_board_p2;
   assign cur.left_click      = click_p1;
   assign cur.packet_valid    = vld_p1;
   assign cur.frame_error     = ferr_p1;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench: drives PS/2 frames and compares cursor behaviour
// against a plain-arithmetic model of the mouse/cursor rules.
module tb_mouse_cursor_tracker;

   localparam int HALF    = 16;
   localparam int TIMEOUT = 20000;

   logic clk;
   logic rst;
   logic ps2_clk;
   logic ps2_data;

   mouse_cursor_tracker_if cur ();

   mouse_cursor_tracker dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .cur      (cur.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int pv_cnt = 0, lc_cnt = 0, fe_cnt = 0;
   int cap_x = 0, cap_y = 0;

   int m_x, m_y, m_pos, m_click;
   bit m_prev, m_on;

   always @(negedge clk) begin
      if (rst) begin
         if (cur.packet_valid) begin
            pv_cnt++;
            cap_x = int'(cur.cursor_x);
            cap_y = int'(cur.cursor_y);
         end
         if (cur.left_click)  lc_cnt++;
         if (cur.frame_error) fe_cnt++;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int v, input int hi);
      if (v < 0)  return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      m_x = 320; m_y = 240; m_prev = 1'b0;
      m_on = 1'b1; m_pos = (240 / 60) * 8 + (320 - 80) / 60;
   endtask

   task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
      int ddx, ddy;
      ddx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
      ddy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
      m_x = clamp(m_x + ddx, 639);
      m_y = clamp(m_y - ddy, 479);
      m_click = (b0[0] && !m_prev) ? 1 : 0;
      m_prev = b0[0];
      m_on = (m_x >= 80) && (m_x < 560) && (m_y < 480);
      if (m_on)
         m_pos = (m_y / 60) * 8 + (m_x - 80) / 60;
   endtask

   task automatic check_outputs();
      @(negedge clk);
      check("cursor_x", int'(cur.cursor_x), m_x);
      check("cursor_y", int'(cur.cursor_y), m_y);
      check("on_board", int'(cur.on_board), int'(m_on));
      check("cursor_position", int'(cur.cursor_position), m_pos);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      logic p;
      p = (~^b) ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++)
         ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
      int pv0, lc0, fe0;
      pv0 = pv_cnt; lc0 = lc_cnt; fe0 = fe_cnt;
      send_byte(b0, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
      repeat (8) @(posedge clk);
      model_packet(b0, b1, b2);
      check("packet_valid_count", pv_cnt - pv0, 1);
      check("left_click_count", lc_cnt - lc0, m_click);
      check("frame_error_count", fe_cnt - fe0, 0);
      check("x_at_valid", cap_x, m_x);
      check("y_at_valid", cap_y, m_y);
      check_outputs();
   endtask

   initial begin
      int pv0, fe0;
      logic [7:0] rb0, rb1, rb2;

      rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_cursor_x", int'(cur.cursor_x), 320);
      check("rst_cursor_y", int'(cur.cursor_y), 240);
      check("rst_on_board", int'(cur.on_board), 0);
      check("rst_position", int'(cur.cursor_position), 0);
      check("rst_pulses", int'({cur.left_click, cur.packet_valid, cur.frame_error}), 0);
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      check_outputs();

      send_packet(8'h08, 8'h0A, 8'h05);
      send_packet(8'h18, 8'h00, 8'h00);
      send_packet(8'h18, 8'h00, 8'h00);
      send_packet(8'h09, 8'h00, 8'h00);
      send_packet(8'h09, 8'h00, 8'h00);
      send_packet(8'h08, 8'h00, 8'h00);
      send_packet(8'h09, 8'h00, 8'h00);

      // bad parity
      pv0 = pv_cnt; fe0 = fe_cnt;
      send_byte(8'h08, 1'b1);
      repeat (8) @(posedge clk);
      check("parity_frame_error", fe_cnt - fe0, 1);
      check("parity_no_valid", pv_cnt - pv0, 0);
      check_outputs();
      send_packet(8'h28, 8'h64, 8'h20);

      // stray header without bit3
      fe0 = fe_cnt; pv0 = pv_cnt;
      send_byte(8'h05, 1'b0);
      repeat (8) @(posedge clk);
      check("stray_no_error", fe_cnt - fe0, 0);
      check("stray_no_valid", pv_cnt - pv0, 0);
      send_packet(8'h08, 8'h32, 8'h10);

      // stalled clock mid-frame
      fe0 = fe_cnt; pv0 = pv_cnt;
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      repeat (TIMEOUT + 50) @(posedge clk);
      check("timeout_frame_error", fe_cnt - fe0, 1);
      check("timeout_no_valid", pv_cnt - pv0, 0);
      send_packet(8'h38, 8'hF0, 8'hF0);

      // reset mid-packet and mid-frame
      send_byte(8'h08, 1'b0);
      ps2_bit(1'b0); ps2_bit(1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      check_outputs();
      send_packet(8'h09, 8'h05, 8'h05);

      for (int n = 0; n < 16; n++) begin
         rb0 = 8'($urandom) | 8'h08;
         if ($urandom_range(0, 7) != 0)
            rb0[7:6] = 2'b00;
         rb1 = 8'($urandom);
         rb2 = 8'($urandom);
         send_packet(rb0, rb1, rb2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
